// File: rtl/tone_synth_pkg.sv
// Shared types and constants for the tone synthesiser: envelope states, sample/step widths,
// peak envelope level and the sign/magnitude-to-two's-complement helper.
package tone_synth_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned STEP_W   = 16;

    localparam logic [SAMPLE_W-1:0] ENV_PEAK = 16'h7FFF;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

    // Magnitude never exceeds ENV_PEAK, so the negation cannot overflow.
    function automatic logic [SAMPLE_W-1:0] signed_level(input logic neg,
                                                         input logic [SAMPLE_W-1:0] mag);
        return neg ? SAMPLE_W'(SAMPLE_W'(0) - mag) : mag;
    endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Note/sample bus between the player/codec side (master) and tone_synth (slave).
interface tone_synth_if;
    import tone_synth_pkg::*;

    logic [STEP_W-1:0]   note_step;
    logic                note_valid;
    logic                sample_req;
    logic                mute;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                busy;

    modport master (
        output note_step, note_valid, sample_req, mute,
        input  sample, sample_valid, busy
    );

    modport slave (
        input  note_step, note_valid, sample_req, mute,
        output sample, sample_valid, busy
    );

endinterface

// File: rtl/tone_env.sv
// Envelope FSM with saturating level. Ramped ATTACK/RELEASE when TONE_SYNTH_ENVELOPE_EN
// is defined; otherwise the level steps straight between 0 and ENV_PEAK.
module tone_env
    import tone_synth_pkg::*;
#(
    parameter logic [STEP_W-1:0] ATTACK_STEP  = 16'd512,
    parameter logic [STEP_W-1:0] RELEASE_STEP = 16'd256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                rest,
    input  logic                tick,
    output logic [SAMPLE_W-1:0] env,
    output logic                busy
);

    env_state_t state;

`ifdef TONE_SYNTH_ENVELOPE_EN

    logic [SAMPLE_W:0] att_sum;
    assign att_sum = {1'b0, env} + {1'b0, ATTACK_STEP};

    // Note events take priority; a coincident tick leaves the level for the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENV_IDLE;
            env   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            state <= ENV_ATTACK;
            busy  <= 1'b1;
        end else if (rest) begin
            if (state != ENV_IDLE) begin
                state <= ENV_RELEASE;
                busy  <= 1'b1;
            end
        end else if (tick) begin
            case (state)
                ENV_ATTACK: begin
                    if (att_sum >= {1'b0, ENV_PEAK}) begin
                        env   <= ENV_PEAK;
                        state <= ENV_SUSTAIN;
                    end else begin
                        env <= att_sum[SAMPLE_W-1:0];
                    end
                end
                ENV_RELEASE: begin
                    if (env <= RELEASE_STEP) begin
                        env   <= '0;
                        state <= ENV_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        env <= env - RELEASE_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

`else

    logic unused_cfg;
    assign unused_cfg = ^{ATTACK_STEP, RELEASE_STEP, tick, state};

    // Level jumps directly: note start -> full scale, rest -> silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENV_IDLE;
            env   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            state <= ENV_SUSTAIN;
            env   <= ENV_PEAK;
            busy  <= 1'b1;
        end else if (rest) begin
            state <= ENV_IDLE;
            env   <= '0;
            busy  <= 1'b0;
        end
    end

`endif

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone synthesiser: phase accumulator, note tracking and registered output stage.
// Envelope shaping lives in tone_env; TONE_SYNTH_ENVELOPE_EN selects ramped envelopes.
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter logic [STEP_W-1:0] ATTACK_STEP  = 16'd512,
    parameter logic [STEP_W-1:0] RELEASE_STEP = 16'd256
) (
    input  logic         clk,
    input  logic         rst_n,
    tone_synth_if.slave  bus
);

    logic [STEP_W-1:0]   phase;
    logic [STEP_W-1:0]   cur_step;
    logic [SAMPLE_W-1:0] env;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                busy;
    logic                start_c;
    logic                rest_c;

    // A repeated nonzero note is a tie, not a retrigger.
    assign start_c = bus.note_valid && (bus.note_step != '0) && (bus.note_step != cur_step);
    assign rest_c  = bus.note_valid && (bus.note_step == '0);

    tone_env #(
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_env (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_c),
        .rest  (rest_c),
        .tick  (bus.sample_req),
        .env   (env),
        .busy  (busy)
    );

    // Samples use pre-update phase/env; a new note clears phase over any coincident advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= '0;
            cur_step     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= bus.sample_req;
            if (bus.sample_req) begin
                sample <= bus.mute ? '0 : signed_level(phase[STEP_W-1], env);
            end
            if (bus.note_valid) begin
                cur_step <= bus.note_step;
            end
            if (start_c) begin
                phase <= '0;
            end else if (bus.sample_req) begin
                phase <= phase + cur_step;
            end
        end
    end

    assign bus.sample       = sample;
    assign bus.sample_valid = sample_valid;
    assign bus.busy         = busy;

endmodule

// File: tb/tb_tone_synth.sv
// Directed self-checking bench for tone_synth; covers either build of TONE_SYNTH_ENVELOPE_EN.
module tb_tone_synth;

    localparam logic [15:0] POS = 16'h7FFF;
    localparam logic [15:0] NEG = 16'h8001;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    tone_synth_if bus ();

    tone_synth dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One sample_req pulse; returns on the falling edge after the capturing edge.
    task automatic req();
        @(negedge clk) bus.sample_req = 1'b1;
        @(negedge clk) bus.sample_req = 1'b0;
    endtask

    task automatic note(input logic [15:0] step);
        @(negedge clk);
        bus.note_valid = 1'b1;
        bus.note_step  = step;
        @(negedge clk) bus.note_valid = 1'b0;
    endtask

    task automatic check_sample(input string tag, input logic [15:0] exp);
        check({tag, "_valid"}, 16'(bus.sample_valid), 16'd1);
        check(tag, bus.sample, exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.note_step  = '0;
        bus.note_valid = 1'b0;
        bus.sample_req = 1'b0;
        bus.mute       = 1'b0;

        #1;
        check("rst_sample", bus.sample, 16'd0);
        check("rst_valid", 16'(bus.sample_valid), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        @(negedge clk) rst_n = 1'b1;

        req();
        check_sample("idle_sample", 16'd0);
        @(negedge clk);
        check("valid_drop", 16'(bus.sample_valid), 16'd0);
        check("idle_busy", 16'(bus.busy), 16'd0);

`ifndef TONE_SYNTH_ENVELOPE_EN
        // Full-scale square at step 0x1000: 8 positive then 8 negative samples.
        note(16'h1000);
        check("note_busy", 16'(bus.busy), 16'd1);
        for (int k = 1; k <= 16; k++) begin
            req();
            check_sample($sformatf("sq_%0d", k), (k <= 8) ? POS : NEG);
        end

        // Advance to phase 0x9000 so the coincident note sample is negative.
        for (int k = 0; k < 9; k++) begin
            req();
            check_sample($sformatf("pre_%0d", k), (k < 8) ? POS : NEG);
        end
        @(negedge clk);
        bus.note_valid = 1'b1;
        bus.note_step  = 16'h2000;
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.note_valid = 1'b0;
        bus.sample_req = 1'b0;
        check_sample("coincident", NEG);
        for (int k = 0; k < 16; k++) begin
            req();
            check_sample($sformatf("flip4_%0d", k), ((k / 4) % 2 == 0) ? POS : NEG);
        end

        // Mute: zeros but phase keeps moving (0 -> 0x6000 across three reqs).
        bus.mute = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req();
            check_sample($sformatf("mute_%0d", k), 16'd0);
        end
        bus.mute = 1'b0;
        req(); check_sample("unmute_0", POS);
        req(); check_sample("unmute_1", NEG);
        req(); check_sample("unmute_2", NEG);
        req(); check_sample("unmute_3", NEG);

        // Repeat of the same note must not clear phase (0xE000 stays negative).
        note(16'h2000);
        req();
        check_sample("tie_no_retrig", NEG);

        note(16'h0000);
        check("rest_busy", 16'(bus.busy), 16'd0);
        req();
        check_sample("rest_sample", 16'd0);

        // Asynchronous reset in mid-note, checked before any clock edge.
        note(16'h1000);
        req();
        check_sample("pre_reset", POS);
        #2 rst_n = 1'b0;
        #1;
        check("async_sample", bus.sample, 16'd0);
        check("async_valid", 16'(bus.sample_valid), 16'd0);
        check("async_busy", 16'(bus.busy), 16'd0);
        @(negedge clk) rst_n = 1'b1;

        note(16'h1000);
        check("fresh_busy", 16'(bus.busy), 16'd1);
        for (int k = 1; k <= 9; k++) begin
            req();
            if (k == 1 || k == 8 || k == 9)
                check_sample($sformatf("fresh_%0d", k), (k <= 8) ? POS : NEG);
        end
`else
        // Attack: 512 per req from 0 saturates on the 64th req.
        note(16'h1000);
        check("att_busy", 16'(bus.busy), 16'd1);
        for (int k = 1; k <= 64; k++) begin
            req();
            if (k == 1) check_sample("att_1", 16'd0);
            if (k == 2) check_sample("att_2", 16'h0200);
            if (k == 3) check_sample("att_3", 16'h0400);
        end
        check("att_busy64", 16'(bus.busy), 16'd1);
        req();
        check_sample("att_65", POS);

        // Release: 256 per req from 0x7FFF reaches 0 on the 128th req.
        note(16'h0000);
        check("rel_busy", 16'(bus.busy), 16'd1);
        for (int k = 1; k <= 128; k++) begin
            req();
            if (k == 1) check_sample("rel_1", POS);
            if (k == 2) check_sample("rel_2", 16'h7EFF);
            if (k == 127) check("rel_busy127", 16'(bus.busy), 16'd1);
        end
        check("rel_busy128", 16'(bus.busy), 16'd0);
        req();
        check_sample("rel_done", 16'd0);

        note(16'h1000);
        req();
        req();
        check_sample("pre_reset", 16'h0200);
        #2 rst_n = 1'b0;
        #1;
        check("async_sample", bus.sample, 16'd0);
        check("async_valid", 16'(bus.sample_valid), 16'd0);
        check("async_busy", 16'(bus.busy), 16'd0);
        @(negedge clk) rst_n = 1'b1;

        note(16'h1000);
        check("fresh_busy", 16'(bus.busy), 16'd1);
        req();
        check_sample("fresh_1", 16'd0);
        req();
        check_sample("fresh_2", 16'h0200);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 Parameter ATTACK_STEP, default 16'd512: envelope increment per sample_req during ATTACK.
REQ-002 Parameter RELEASE_STEP, default 16'd256: envelope decrement per sample_req during RELEASE.
REQ-003 clk  input  1: single system clock; all state on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 note_step  input  16: phase increment per 48 kHz sample (player note word); 0 = rest.
REQ-006 note_valid  input  1: one-cycle strobe qualifying note_step.
REQ-007 sample_req  input  1: one-cycle codec sample tick (48 kHz).
REQ-008 mute  input  1: level; forces sample output to 0.
REQ-009 sample  output  16: signed two's-complement audio sample.
REQ-010 sample_valid  output  1: one-cycle pulse, sample updated.
REQ-011 busy  output  1: high while envelope state is not IDLE.

Function
REQ-012 On note_valid, cur_step SHALL load note_step at that edge.
REQ-013 On note_valid with note_step nonzero and different from cur_step: phase SHALL clear to 0, envelope SHALL enter ATTACK.
REQ-014 On note_valid with note_step equal to nonzero cur_step: no retrigger; phase, envelope unchanged.
REQ-015 On note_valid with note_step 0: envelope SHALL enter RELEASE (stay IDLE if already IDLE).
REQ-016 On sample_req edge: sample <= (phase[15] ? -env : +env) using pre-update phase/env; phase <= phase + cur_step, modulo 2^16; env updated per state.
REQ-017 sample_valid SHALL pulse in the cycle after sample_req (latency 1); no pulse without sample_req.
REQ-018 Envelope states IDLE, ATTACK, SUSTAIN, RELEASE; IDLE env=0; ATTACK env+=ATTACK_STEP saturating at 16'h7FFF, then SUSTAIN; SUSTAIN holds; RELEASE env-=RELEASE_STEP saturating at 0, then IDLE.
REQ-019 env SHALL never exceed 16'h7FFF, so negation never overflows.
REQ-020 note_valid and sample_req in same cycle: the sample SHALL use old cur_step/env/phase; new note effective from next sample_req.
REQ-021 mute high: sample output 0, sample_valid still pulses; phase/envelope continue advancing.
REQ-022 busy SHALL follow registered state (updates with state, no extra lag).

Reset
REQ-023 rst_n low SHALL immediately clear sample, sample_valid, busy, phase, cur_step, env to 0 and state to IDLE, including mid-ATTACK/RELEASE.
REQ-024 First note after reset deassertion SHALL behave as a fresh note from IDLE.

Configuration
REQ-025 Macro TONE_SYNTH_ENVELOPE_EN defined: ramped envelope per REQ-018.
REQ-026 Macro undefined: env jumps to 16'h7FFF on note start (state SUSTAIN), to 0 on rest (state IDLE); ATTACK/RELEASE unreachable; ATTACK_STEP/RELEASE_STEP ignored.

Structure
REQ-027 Package tone_synth_pkg SHALL hold envelope state enum, ENV_PEAK = 16'h7FFF, sample width constant.
REQ-028 Envelope FSM and saturation SHALL be sub-module tone_env; phase accumulator and output stage in tone_synth.

Verification
REQ-029 rst_n low mid-operation -> sample=0, sample_valid=0, busy=0 same cycle, without clock.
REQ-030 Macro off, note_step=16'h1000 note_valid, 16 sample_req -> samples 1-8 = +16'h7FFF, 9-16 = -16'h7FFF.
REQ-031 Macro on, step 16'h1000, 65 sample_req -> busy=1; env saturates after 64 reqs; 65th sample = +16'h7FFF; state SUSTAIN.
REQ-032 From SUSTAIN, note_step=0 note_valid -> env reaches 0 after 128 sample_req; state IDLE, busy=0; further samples 0.
REQ-033 note_valid(16'h2000) coincident with sample_req during 16'h1000 note -> that sample uses old step; phase cleared; subsequent samples flip sign every 4 reqs.
REQ-034 mute=1 during SUSTAIN -> sample=0, sample_valid pulses each req; mute=0 -> sign pattern resumes with phase continuity.
